tetromino_spawner: RTL
======================

TETROMINO_SPAWNER -- requirements
Module: tetromino_spawner

Interface
REQ-001 SHALL have parameter SPAWN_X, default 3, meaning the x coordinate given to every spawned or swapped-in piece.
REQ-002 SHALL have parameter CHECK_TIMEOUT, default 15, meaning the max cycles to wait for check_done before treating the check as a collision.
REQ-003 SHALL use one clock and an asynchronous active-high reset; ports: clk  in  1  system clock; reset  in  1  asynchronous active-high reset.
REQ-004 spawn_req  in  1  pulse from game FSM requesting a new active piece.
REQ-005 hold_req  in  1  pulse requesting a hold/swap of the active piece.
REQ-006 gen_curr  in  tetromino_ctrl  current piece from the random generator.
REQ-007 gen_enable  out  1  one-cycle advance strobe to the generator.
REQ-008 check_req / check_piece / check_done / check_collide  out 1 / out tetromino_ctrl / in 1 / in 1  board collision-check handshake.
REQ-009 active  out  tetromino_ctrl  current falling piece; active_valid  out  1.
REQ-010 hold_idx  out  tetromino_idx_t; hold_valid  out  1; hold_used  out  1.
REQ-011 busy  out  1; spawn_done  out  1 (one-cycle pulse); game_over  out  1 (sticky).

Function
REQ-012 SHALL implement FSM states IDLE, ADVANCE, LATCH, CHECK, DONE, OVER.
REQ-013 IDLE: spawn_req -> ADVANCE; else hold_req with active_valid=1 and hold_used=0 -> hold path (REQ-018/019); spawn_req takes priority over a simultaneous hold_req.
REQ-014 ADVANCE: gen_enable=1 for exactly this one cycle; next state LATCH.
REQ-015 LATCH: candidate register <= gen_curr; next state CHECK.
REQ-016 CHECK: check_req=1 and check_piece=candidate held stable until check_done sampled high; check_done with check_collide=0 -> DONE; check_done with check_collide=1 -> OVER; no check_done within CHECK_TIMEOUT cycles -> OVER.
REQ-017 DONE: active<=candidate and active_valid<=1 on entry; spawn_done=1 for this one cycle; next state IDLE.
REQ-018 Hold with hold_valid=0: hold_idx<=active.idx, hold_valid<=1, hold_used<=1, active_valid<=0, then ADVANCE (new piece from generator).
REQ-019 Hold with hold_valid=1: hold_idx<=active.idx, hold_used<=1, candidate<=swap piece built from old hold_idx, state -> CHECK directly (no gen_enable).
REQ-020 Swap piece: idx=old hold_idx, rotation=0, x=SPAWN_X, y=0 for I, -1 otherwise; tetromino field from get_tetromino_info.
REQ-021 hold_used SHALL clear when DONE is reached via spawn_req path; stays set through a hold-path DONE.
REQ-022 busy=1 in every state except IDLE; spawn_req/hold_req outside IDLE SHALL be ignored (not queued).
REQ-023 OVER: game_over=1, active_valid=0, check_req=0, gen_enable=0; stays in OVER until reset.
REQ-024 With a zero-wait checker (check_done same cycle as check_req), spawn_req at cycle N SHALL give gen_enable at N+1 and spawn_done at N+4.
REQ-025 gen_enable SHALL never be asserted in any state but ADVANCE.

Reset
REQ-026 Reset SHALL force state IDLE, gen_enable=0, check_req=0, active_valid=0, hold_valid=0, hold_used=0, hold_idx=0, spawn_done=0, game_over=0, busy=0, active and candidate cleared to 0.
REQ-027 Reset asserted mid-operation (any state incl. OVER) SHALL take effect immediately and abandon any outstanding check without a spawn_done pulse.

Verification
REQ-028 Spawn, zero-wait checker, gen_curr.idx=2 after advance, check_collide=0 -> gen_enable high only at N+1, spawn_done at N+4, active.idx=2, rotation 0, x=3.
REQ-029 Checker delays check_done 5 cycles -> check_req and check_piece stable for 6 cycles, spawn_done exactly one cycle after done sampled.
REQ-030 Active idx=4, hold empty, hold_req -> hold_idx=4, hold_valid=1, one gen_enable, new piece active; second hold_req before next spawn_req ignored.
REQ-031 Hold holds idx=I, active idx=5, hold_req after fresh spawn -> no gen_enable, active.idx=I at y=0, x=3, hold_idx=5.
REQ-032 check_collide=1 on spawn -> game_over=1, active_valid=0, further spawn_req ignored; reset clears game_over; checker silent 15 cycles -> OVER.
REQ-033 Simultaneous spawn_req and hold_req in IDLE -> spawn path taken, hold state unchanged.

Source files
------------

// File: rtl/tetromino_spawner.sv
// Tetromino spawner: pulls a new piece from the generator or swaps with the hold slot,
// runs the board collision check, and publishes the accepted piece as the active piece.

package tetromino_pkg;

    // 0=I 1=O 2=T 3=S 4=Z 5=J 6=L
    typedef logic [2:0] tetromino_idx_t;

    typedef struct packed {
        tetromino_idx_t     idx;
        logic [1:0]         rotation;
        logic signed [4:0]  x;
        logic signed [5:0]  y;
        logic [15:0]        tetromino;  // 4x4 bitmap, row 0 in the top nibble
    } tetromino_ctrl;

    // Spawn-orientation bitmap for each piece
    function automatic logic [15:0] get_tetromino_info(input tetromino_idx_t idx);
        logic [15:0] shape;
        unique case (idx)
            3'd0:    shape = 16'h0F00;
            3'd1:    shape = 16'h6600;
            3'd2:    shape = 16'h4E00;
            3'd3:    shape = 16'h6C00;
            3'd4:    shape = 16'hC600;
            3'd5:    shape = 16'h8E00;
            3'd6:    shape = 16'h2E00;
            default: shape = 16'h0000;
        endcase
        return shape;
    endfunction

endpackage

module tetromino_spawner
    import tetromino_pkg::*;
#(
    parameter int          SPAWN_X       = 3,
    parameter int unsigned CHECK_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           spawn_req,
    input  logic           hold_req,
    input  tetromino_ctrl  gen_curr,
    output logic           gen_enable,
    output logic           check_req,
    output tetromino_ctrl  check_piece,
    input  logic           check_done,
    input  logic           check_collide,
    output tetromino_ctrl  active,
    output logic           active_valid,
    output tetromino_idx_t hold_idx,
    output logic           hold_valid,
    output logic           hold_used,
    output logic           busy,
    output logic           spawn_done,
    output logic           game_over
);

    localparam int unsigned TW = (CHECK_TIMEOUT > 1) ? $clog2(CHECK_TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StAdvance, StLatch, StCheck, StDone, StOver} state_e;

    state_e         state_q, state_d;
    tetromino_ctrl  cand_q, cand_d;
    tetromino_ctrl  active_q, active_d;
    logic           active_valid_q, active_valid_d;
    tetromino_idx_t hold_idx_q, hold_idx_d;
    logic           hold_valid_q, hold_valid_d;
    logic           hold_used_q, hold_used_d;
    logic           from_hold_q, from_hold_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           gen_enable_q, gen_enable_d;
    logic           check_req_q, check_req_d;
    logic           spawn_done_q, spawn_done_d;
    logic           game_over_q, game_over_d;
    logic           busy_q, busy_d;
    tetromino_ctrl  swap_piece;

    // Piece rebuilt from the current hold slot for a swap
    always_comb begin
        swap_piece           = '0;
        swap_piece.idx       = hold_idx_q;
        swap_piece.rotation  = 2'd0;
        swap_piece.x         = 5'(SPAWN_X);
        swap_piece.y         = (hold_idx_q == 3'd0) ? 6'sd0 : -6'sd1;
        swap_piece.tetromino = get_tetromino_info(hold_idx_q);
    end

    // Next-state logic; outputs are derived from the next state so they come out registered
    always_comb begin
        state_d        = state_q;
        cand_d         = cand_q;
        active_d       = active_q;
        active_valid_d = active_valid_q;
        hold_idx_d     = hold_idx_q;
        hold_valid_d   = hold_valid_q;
        hold_used_d    = hold_used_q;
        from_hold_d    = from_hold_q;
        timer_d        = timer_q;
        spawn_done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (spawn_req) begin
                    from_hold_d = 1'b0;
                    state_d     = StAdvance;
                end else if (hold_req && active_valid_q && !hold_used_q) begin
                    hold_idx_d     = active_q.idx;
                    hold_used_d    = 1'b1;
                    active_valid_d = 1'b0;
                    from_hold_d    = 1'b1;
                    if (!hold_valid_q) begin
                        hold_valid_d = 1'b1;
                        state_d      = StAdvance;
                    end else begin
                        cand_d  = swap_piece;
                        timer_d = '0;
                        state_d = StCheck;
                    end
                end
            end
            StAdvance: state_d = StLatch;
            StLatch: begin
                cand_d  = gen_curr;
                timer_d = '0;
                state_d = StCheck;
            end
            StCheck: begin
                if (check_done) begin
                    state_d = check_collide ? StOver : StDone;
                end else if (timer_q == TW'(CHECK_TIMEOUT - 1)) begin
                    state_d = StOver;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StOver:  state_d = StOver;
            default: state_d = StIdle;
        endcase

        // Only CHECK leads to DONE, so this fires once on entry
        if (state_d == StDone) begin
            active_d       = cand_q;
            active_valid_d = 1'b1;
            spawn_done_d   = 1'b1;
            if (!from_hold_q) begin
                hold_used_d = 1'b0;
            end
        end
        if (state_d == StOver) begin
            active_valid_d = 1'b0;
        end

        gen_enable_d = (state_d == StAdvance);
        check_req_d  = (state_d == StCheck);
        busy_d       = (state_d != StIdle);
        game_over_d  = (state_d == StOver);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cand_q         <= '0;
            active_q       <= '0;
            active_valid_q <= 1'b0;
            hold_idx_q     <= '0;
            hold_valid_q   <= 1'b0;
            hold_used_q    <= 1'b0;
            from_hold_q    <= 1'b0;
            timer_q        <= '0;
            gen_enable_q   <= 1'b0;
            check_req_q    <= 1'b0;
            spawn_done_q   <= 1'b0;
            game_over_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cand_q         <= cand_d;
            active_q       <= active_d;
            active_valid_q <= active_valid_d;
            hold_idx_q     <= hold_idx_d;
            hold_valid_q   <= hold_valid_d;
            hold_used_q    <= hold_used_d;
            from_hold_q    <= from_hold_d;
            timer_q        <= timer_d;
            gen_enable_q   <= gen_enable_d;
            check_req_q    <= check_req_d;
            spawn_done_q   <= spawn_done_d;
            game_over_q    <= game_over_d;
            busy_q         <= busy_d;
        end
    end

    assign gen_enable   = gen_enable_q;
    assign check_req    = check_req_q;
    assign check_piece  = cand_q;
    assign active       = active_q;
    assign active_valid = active_valid_q;
    assign hold_idx     = hold_idx_q;
    assign hold_valid   = hold_valid_q;
    assign hold_used    = hold_used_q;
    assign busy         = busy_q;
    assign spawn_done   = spawn_done_q;
    assign game_over    = game_over_q;

endmodule
